// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, funct codes, decoded-record types,
// instruction encoders and the format/immediate decode helpers.
// Ports: none (package).
package riscv_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_REG_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG_REG = 7'b0110011;

  localparam logic [6:0] F7_ADD_SRL = 7'b0000000;
  localparam logic [6:0] F7_SUB_SRA = 7'b0100000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
  } imm_fmt_t;

  typedef enum logic [1:0] {
    ST_EMPTY, ST_ONE, ST_TWO
  } skid_state_t;

  typedef struct packed {
    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] reg_A;
    logic [RV_XLEN-1:0] reg_B;
    logic [11:0]        imm;
  } decoded_instr_t;

  typedef struct packed {
    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] reg_A;
    logic [RV_XLEN-1:0] reg_B;
    logic [31:0]        imm;
    imm_fmt_t           fmt;
    logic               illegal;
  } decoded_instr_ext_t;

  function automatic imm_fmt_t opcode_to_fmt(input logic [6:0] opcode);
    case (opcode)
      OP_REG_REG:                   return FMT_R;
      OP_REG_IMM, OP_LOAD, OP_JALR: return FMT_I;
      OP_STORE:                     return FMT_S;
      OP_BRANCH:                    return FMT_B;
      OP_LUI, OP_AUIPC:             return FMT_U;
      OP_JAL:                       return FMT_J;
      default:                      return FMT_NONE;
    endcase
  endfunction

  function automatic logic [31:0] decode_imm(input logic [31:0] instr, input imm_fmt_t fmt);
    case (fmt)
      FMT_I:   return {{20{instr[31]}}, instr[31:20]};
      FMT_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   return {instr[31:12], 12'b0};
      FMT_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] encode_r_type(input logic [6:0] funct7, input logic [4:0] rs2,
                                                input logic [4:0] rs1, input logic [2:0] funct3,
                                                input logic [4:0] rd, input logic [6:0] opcode);
    return {funct7, rs2, rs1, funct3, rd, opcode};
  endfunction

  function automatic logic [31:0] encode_i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                                input logic [2:0] funct3, input logic [4:0] rd,
                                                input logic [6:0] opcode);
    return {imm, rs1, funct3, rd, opcode};
  endfunction

  function automatic logic [31:0] encode_s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                                input logic [4:0] rs1, input logic [2:0] funct3,
                                                input logic [6:0] opcode);
    return {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
  endfunction

  // Branch/jump offsets are always even, so only bits [n:1] are taken.
  function automatic logic [31:0] encode_b_type(input logic [12:1] imm, input logic [4:0] rs2,
                                                input logic [4:0] rs1, input logic [2:0] funct3,
                                                input logic [6:0] opcode);
    return {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
  endfunction

  function automatic logic [31:0] encode_u_type(input logic [31:12] imm, input logic [4:0] rd,
                                                input logic [6:0] opcode);
    return {imm, rd, opcode};
  endfunction

  function automatic logic [31:0] encode_j_type(input logic [20:1] imm, input logic [4:0] rd,
                                                input logic [6:0] opcode);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
  endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Purpose: classify instruction format from opcode and rebuild the 32-bit immediate.
// Latency: combinational. Backpressure: none (pure function of instr).
// Ports: instr (raw word) -> fmt (imm_fmt_t), imm (sign-extended immediate).
module rv32i_imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output imm_fmt_t    fmt,
  output logic [31:0] imm
);

  assign fmt = opcode_to_fmt(instr[6:0]);
  assign imm = decode_imm(instr, fmt);

endmodule

// File: rtl/rv32i_decode_stage.sv
// Purpose: RV32I decode stage; splits fields, rebuilds immediates, captures register reads.
// Latency: 1 cycle from accept to out_valid; 1 instruction/cycle sustained.
// Backpressure: two-entry skid buffer; in_ready is registered and drops only when both entries are full.
// Ports: clk/rst_n (sync, active-low), flush; in_valid/in_ready/in_instr/in_pc from fetch;
//        rf_rs{1,2}_addr out / rf_rs{1,2}_data in (same-cycle register file read);
//        out_valid/out_ready/out_dec to execute.
// Optional: define ILLEGAL_CHECK_EN to compute the illegal flag; otherwise it is tied to 0.
module rv32i_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = RV_XLEN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [XLEN-1:0]    in_pc,
  output logic [4:0]         rf_rs1_addr,
  output logic [4:0]         rf_rs2_addr,
  input  logic [XLEN-1:0]    rf_rs1_data,
  input  logic [XLEN-1:0]    rf_rs2_data,
  output logic               out_valid,
  input  logic               out_ready,
  output decoded_instr_ext_t out_dec
);

  imm_fmt_t           fmt;
  logic [31:0]        imm;
  logic               illegal;
  logic               keep_f7;
  decoded_instr_ext_t new_dec;
  decoded_instr_ext_t skid_dec;
  skid_state_t        state;
  logic               accept;
  logic               out_xfer;

  // Register file addresses come straight from the raw word, valid or not.
  assign rf_rs1_addr = in_instr[19:15];
  assign rf_rs2_addr = in_instr[24:20];

  rv32i_imm_gen u_imm_gen (
    .instr (in_instr),
    .fmt   (fmt),
    .imm   (imm)
  );

  // funct7 survives for R-type and for shift-immediates, where it selects SRLI/SRAI.
  assign keep_f7 = (fmt == FMT_R) ||
                   ((in_instr[6:0] == OP_REG_IMM) &&
                    ((in_instr[14:12] == F3_SLL) || (in_instr[14:12] == F3_SRL_SRA)));

  always_comb begin
    new_dec         = '0;
    new_dec.opcode  = in_instr[6:0];
    new_dec.rd      = ((fmt == FMT_S) || (fmt == FMT_B)) ? 5'd0 : in_instr[11:7];
    new_dec.rs1     = ((fmt == FMT_U) || (fmt == FMT_J)) ? 5'd0 : in_instr[19:15];
    new_dec.rs2     = ((fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J)) ? 5'd0 : in_instr[24:20];
    new_dec.funct3  = ((fmt == FMT_U) || (fmt == FMT_J)) ? 3'd0 : in_instr[14:12];
    new_dec.funct7  = keep_f7 ? in_instr[31:25] : 7'd0;
    new_dec.pc      = in_pc;
    // A zero rs field covers both the unused-operand case and x0 reads.
    new_dec.reg_A   = (new_dec.rs1 == 5'd0) ? '0 : rf_rs1_data;
    new_dec.reg_B   = (new_dec.rs2 == 5'd0) ? '0 : rf_rs2_data;
    new_dec.imm     = imm;
    new_dec.fmt     = fmt;
    new_dec.illegal = illegal;
  end

`ifdef ILLEGAL_CHECK_EN
  logic [2:0] chk_f3;
  logic [6:0] chk_f7;
  assign chk_f3 = in_instr[14:12];
  assign chk_f7 = in_instr[31:25];

  always_comb begin
    illegal = 1'b0;
    if ((in_instr[1:0] != 2'b11) || (fmt == FMT_NONE)) illegal = 1'b1;
    case (in_instr[6:0])
      OP_REG_REG: begin
        if ((chk_f7 != F7_ADD_SRL) && (chk_f7 != F7_SUB_SRA))
          illegal = 1'b1;
        else if ((chk_f7 == F7_SUB_SRA) && (chk_f3 != F3_ADD_SUB) && (chk_f3 != F3_SRL_SRA))
          illegal = 1'b1;
      end
      OP_REG_IMM: begin
        if ((chk_f3 == F3_SLL) && (chk_f7 != F7_ADD_SRL))
          illegal = 1'b1;
        else if ((chk_f3 == F3_SRL_SRA) && (chk_f7 != F7_ADD_SRL) && (chk_f7 != F7_SUB_SRA))
          illegal = 1'b1;
      end
      OP_JALR:   if (chk_f3 != 3'd0) illegal = 1'b1;
      OP_LOAD:   if ((chk_f3 == 3'd3) || (chk_f3 == 3'd6) || (chk_f3 == 3'd7)) illegal = 1'b1;
      OP_STORE:  if (chk_f3 > 3'd2) illegal = 1'b1;
      OP_BRANCH: if ((chk_f3 == 3'd2) || (chk_f3 == 3'd3)) illegal = 1'b1;
      default: ;
    endcase
  end
`else
  assign illegal = 1'b0;
`endif

  assign accept   = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // out_dec is the head entry; skid_dec only holds data in ST_TWO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_dec   <= '0;
      skid_dec  <= '0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_dec   <= new_dec;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !out_xfer) begin
            skid_dec <= new_dec;
            in_ready <= 1'b0;
            state    <= ST_TWO;
          end else if (accept && out_xfer) begin
            out_dec <= new_dec;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            out_dec  <= skid_dec;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
